// File: rtl/pe_pkg.sv
// Shared constants, state encoding and saturation helpers for the PE datapath.
package pe_pkg;

   localparam int PE_DATA_W = 8;
   localparam int PE_ACC_W  = 16;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Largest and smallest two's-complement values representable in w bits.
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Plain N-bit ripple-style adder with carry in and carry out.
module n_bit_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/pe_accumulator.sv
// Framed signed accumulator: sums beats until in_last, saturates on overflow,
// and holds one result per frame on a valid/ready output.
module pe_accumulator
   import pe_pkg::*;
#(
   parameter int DATA_W = PE_DATA_W,
   parameter int ACC_W  = PE_ACC_W,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic        [CNT_W-1:0]  out_count,
   output logic                     out_sat
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic        [CNT_W-1:0]  cnt_q;
   logic                     sat_q;

   logic                     accept;
   logic signed [ACC_W-1:0]  operand;
   logic        [ACC_W-1:0]  sum_raw;
   logic                     carry_unused;
   logic                     ovf_pos, ovf_neg;
   logic signed [ACC_W-1:0]  acc_next;
   logic        [CNT_W-1:0]  cnt_next;
   logic                     sat_next;

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_HOLD);
   assign accept    = in_valid && in_ready;
   assign operand   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

   n_bit_adder #(.N(ACC_W)) u_adder (
      .a   (acc_q),
      .b   (operand),
      .cin (1'b0),
      .sum (sum_raw),
      .cout(carry_unused)
   );

   // Overflow from sign agreement of the operands versus the sum.
   assign ovf_pos  = !acc_q[ACC_W-1] && !operand[ACC_W-1] &&  sum_raw[ACC_W-1];
   assign ovf_neg  =  acc_q[ACC_W-1] &&  operand[ACC_W-1] && !sum_raw[ACC_W-1];
   assign acc_next = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : $signed(sum_raw));
   assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign sat_next = sat_q || ovf_pos || ovf_neg;

   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         ST_ACC:  if (accept && in_last) state_d = ST_HOLD;
         ST_HOLD: if (out_ready)         state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ACC;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            // Publish the frame including this beat and start the next from zero.
            out_data  <= acc_next;
            out_count <= cnt_next;
            out_sat   <= sat_next;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
         end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_next;
            sat_q <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed self-checking bench for pe_accumulator.
module tb_pe_accumulator;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [7:0]  in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic        [7:0]  out_count;
   logic               out_sat;

   int checks   = 0;
   int failures = 0;

   pe_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_sat  (out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one beat from a falling edge, wait for acceptance, return on the next falling edge.
   task automatic send_beat(input logic signed [7:0] d, input logic last);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard == 50) begin
         checks++;
         failures++;
         $display("FAIL send_beat_ready: in_ready=%b expected 1 within 50 cycles", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
      checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic;
      send_beat(8'sd4, 1'b0);
      send_beat(8'sd10, 1'b0);
      send_beat(8'sd20, 1'b0);
      send_beat(8'sd2, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: out_valid=%b expected 1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_ready: in_ready=%b expected 0", in_ready); end
      checks++; if (out_data !== 16'sd36) begin failures++; $display("FAIL basic_data: got %0d expected 36", out_data); end
      checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL basic_count: got %0d expected 4", out_count); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat: got %b expected 0", out_sat); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_drain_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_signed_mix;
      send_beat(-8'sd3, 1'b0);
      send_beat(-8'sd4, 1'b0);
      send_beat(8'sd3, 1'b0);
      send_beat(8'sd4, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mix1_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL mix1_data: got %0d expected 0", out_data); end
      checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL mix1_count: got %0d expected 4", out_count); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL mix1_sat: got %b expected 0", out_sat); end
      @(negedge clk);
      send_beat(-8'sd3, 1'b0);
      send_beat(8'sd4, 1'b1);
      checks++; if (out_data !== 16'sd1) begin failures++; $display("FAIL mix2_data: got %0d expected 1", out_data); end
      checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL mix2_count: got %0d expected 2", out_count); end
      @(negedge clk);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 300; i++) send_beat(8'sd127, (i == 299));
      checks++; if (out_data !== 16'sd32767) begin failures++; $display("FAIL satpos_data: got %0d expected 32767", out_data); end
      checks++; if (out_sat !== 1'b1) begin failures++; $display("FAIL satpos_flag: got %b expected 1", out_sat); end
      checks++; if (out_count !== 8'd255) begin failures++; $display("FAIL satpos_count: got %0d expected 255", out_count); end
      @(negedge clk);
      for (int i = 0; i < 300; i++) send_beat(-8'sd128, (i == 299));
      checks++; if (out_data !== -16'sd32768) begin failures++; $display("FAIL satneg_data: got %0d expected -32768", out_data); end
      checks++; if (out_sat !== 1'b1) begin failures++; $display("FAIL satneg_flag: got %b expected 1", out_sat); end
      checks++; if (out_count !== 8'd255) begin failures++; $display("FAIL satneg_count: got %0d expected 255", out_count); end
      @(negedge clk);
      send_beat(8'sd5, 1'b0);
      send_beat(8'sd5, 1'b1);
      checks++; if (out_data !== 16'sd10) begin failures++; $display("FAIL satclr_data: got %0d expected 10", out_data); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL satclr_flag: got %b expected 0", out_sat); end
      checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL satclr_count: got %0d expected 2", out_count); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_beat(8'sd4, 1'b0);
      send_beat(8'sd10, 1'b0);
      send_beat(8'sd20, 1'b0);
      send_beat(8'sd2, 1'b1);
      in_valid = 1'b1; in_data = 8'sd99; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_data !== 16'sd36) begin failures++; $display("FAIL bp_data[%0d]: got %0d expected 36", i, out_data); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
         @(negedge clk);
      end
      checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL bp_count: got %0d expected 4", out_count); end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      send_beat(8'sd7, 1'b1);
      checks++; if (out_data !== 16'sd7) begin failures++; $display("FAIL bp_resume_data: got %0d expected 7", out_data); end
      checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL bp_resume_count: got %0d expected 1", out_count); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame;
      send_beat(8'sd4, 1'b0);
      send_beat(8'sd10, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL rstmid_data: got %0d expected 0", out_data); end
      checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL rstmid_count: got %0d expected 0", out_count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_beat(8'sd6, 1'b0);
      send_beat(8'sd8, 1'b1);
      checks++; if (out_data !== 16'sd14) begin failures++; $display("FAIL rstmid_after_data: got %0d expected 14", out_data); end
      checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL rstmid_after_count: got %0d expected 2", out_count); end
      @(negedge clk);
   endtask

   task automatic test_single_and_gapped;
      send_beat(-8'sd124, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== -16'sd124) begin failures++; $display("FAIL single_data: got %0d expected -124", out_data); end
      checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", out_count); end
      @(negedge clk);
      send_beat(8'sd38, 1'b0);
      in_last = 1'b1;
      repeat (3) @(negedge clk);
      send_beat(-8'sd124, 1'b1);
      checks++; if (out_data !== -16'sd86) begin failures++; $display("FAIL gapped_data: got %0d expected -86", out_data); end
      checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL gapped_count: got %0d expected 2", out_count); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed_mix();
      test_saturation();
      test_backpressure();
      test_reset_mid_frame();
      test_single_and_gapped();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
